// File: rtl/astro_pkg.sv
// Shared types and helpers for the Astrocade cart loader.
package astro_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MRD,
    MWR,
    DONE
  } state_t;

  localparam logic [7:0] CART_INDEX_DEFAULT = 8'd1;

  // Smallest power of two >= count, clamped to [2^min_log2, 2^max_log2].
  function automatic logic [15:0] pow2_ceil(input logic [15:0] count,
                                            input int unsigned min_log2,
                                            input int unsigned max_log2);
    logic [15:0] p;
    logic        found;
    p     = 16'(32'd1 << max_log2);
    found = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (!found && i >= min_log2 && i <= max_log2 && 32'(count) <= (32'd1 << i)) begin
        p     = 16'(32'd1 << i);
        found = 1'b1;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/astro_size_round.sv
// Rounds the loaded byte count up to the mirror granule; purely combinational.
module astro_size_round
  import astro_pkg::*;
#(
  parameter int unsigned MIN_LOG2 = 11,
  parameter int unsigned MAX_LOG2 = 13
) (
  input  logic [15:0] count,
  output logic [15:0] size
);

  always_comb begin
    size = pow2_ceil(count, MIN_LOG2, MAX_LOG2);
  end

endmodule

// File: rtl/astro_cart_loader.sv
// Cart ROM loader: captures the ioctl cart download and mirrors short images over the window.
// Optional checksum output enabled by defining ASTRO_CART_CSUM_EN.
module astro_cart_loader
  import astro_pkg::*;
#(
  parameter int unsigned ADDR_W     = 13,
  parameter logic [7:0]  CART_INDEX = CART_INDEX_DEFAULT,
  parameter int unsigned MIN_LOG2   = 11
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata,
  output logic              owns_bus,
  output logic [15:0]       cart_size,
  output logic              cart_present,
  output logic              overflow,
`ifdef ASTRO_CART_CSUM_EN
  output logic [7:0]        csum,
`endif
  output logic              mirror_busy
);

  localparam logic [15:0] WIN = 16'(32'd1 << ADDR_W);

  state_t      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] size_q, size_d;
  logic [15:0] dst_q, dst_d;
  logic        ovf_q, ovf_d;
  logic        wr_ok, wr_big, start, load_entry;
  logic [15:0] addr_p1, count_upd, p_size;

  always_comb begin
    wr_ok     = ioctl_wr && (ioctl_addr[24:ADDR_W] == '0);
    wr_big    = ioctl_wr && !wr_ok;
    start     = ioctl_download && (ioctl_index == CART_INDEX);
    addr_p1   = 16'(ioctl_addr[ADDR_W-1:0]) + 16'd1;
    // A byte arriving with the falling edge still counts toward the size.
    count_upd = (wr_ok && addr_p1 > count_q) ? addr_p1 : count_q;
  end

  astro_size_round #(
    .MIN_LOG2(MIN_LOG2),
    .MAX_LOG2(ADDR_W)
  ) u_size_round (
    .count(count_upd),
    .size (p_size)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    size_d     = size_q;
    dst_d      = dst_q;
    ovf_d      = ovf_q;
    load_entry = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_we     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) load_entry = 1'b1;
      end
      LOAD: begin
        if (wr_ok) begin
          mem_addr  = ioctl_addr[ADDR_W-1:0];
          mem_wdata = ioctl_dout;
          mem_we    = 1'b1;
          count_d   = count_upd;
        end
        if (wr_big) ovf_d = 1'b1;
        if (!ioctl_download) begin
          if (count_upd == '0) begin
            state_d = IDLE;
            count_d = '0;
            size_d  = '0;
            ovf_d   = 1'b0;
          end else begin
            size_d = p_size;
            if (p_size == WIN) begin
              state_d = DONE;
            end else begin
              dst_d   = p_size;
              state_d = MRD;
            end
          end
        end
      end
      MRD: begin
        if (start) begin
          load_entry = 1'b1;
        end else begin
          // Source byte lives in the first image copy; RAM returns it next cycle.
          mem_addr = ADDR_W'(dst_q & (size_q - 16'd1));
          state_d  = MWR;
        end
      end
      MWR: begin
        if (start) begin
          load_entry = 1'b1;
        end else begin
          mem_addr  = dst_q[ADDR_W-1:0];
          mem_wdata = mem_rdata;
          mem_we    = 1'b1;
          dst_d     = dst_q + 16'd1;
          state_d   = (dst_q == WIN - 16'd1) ? DONE : MRD;
        end
      end
      DONE: begin
        if (start) load_entry = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (load_entry) begin
      state_d = LOAD;
      count_d = '0;
      size_d  = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      size_q  <= '0;
      dst_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      size_q  <= size_d;
      dst_q   <= dst_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    owns_bus     = (state_q == LOAD) || (state_q == MRD) || (state_q == MWR);
    mirror_busy  = (state_q == MRD) || (state_q == MWR);
    cart_present = (state_q == DONE);
    cart_size    = size_q;
    overflow     = ovf_q;
  end

`ifdef ASTRO_CART_CSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      csum_q <= '0;
    end else if (load_entry) begin
      csum_q <= '0;
    end else if (state_q == LOAD && wr_ok) begin
      csum_q <= csum_q + ioctl_dout;
    end
  end

  assign csum = csum_q;
`endif

endmodule

// File: tb/tb_astro_cart_loader.sv
// Randomized directed bench for astro_cart_loader with a byte-array image model.
// Define ASTRO_CART_CSUM_EN to also exercise the checksum output.
module tb_astro_cart_loader;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [12:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic        owns_bus;
  logic [15:0] cart_size;
  logic        cart_present;
  logic        overflow;
  logic        mirror_busy;
`ifdef ASTRO_CART_CSUM_EN
  logic [7:0]  csum;
`endif

  astro_cart_loader dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .ioctl_download(ioctl_download),
    .ioctl_index   (ioctl_index),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_we        (mem_we),
    .mem_rdata     (mem_rdata),
    .owns_bus      (owns_bus),
    .cart_size     (cart_size),
    .cart_present  (cart_present),
    .overflow      (overflow),
`ifdef ASTRO_CART_CSUM_EN
    .csum          (csum),
`endif
    .mirror_busy   (mirror_busy)
  );

  always #5 clk_sys = ~clk_sys;

  // Cart RAM port A: synchronous write, registered read.
  logic [7:0] ram [8192];
  int we_cnt = 0;
  always @(posedge clk_sys) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
    if (mem_we) we_cnt <= we_cnt + 1;
  end

  // Reference image and download bookkeeping.
  logic [7:0] ref_mem [8192];
  int   m_cnt;
  bit   m_ovf;
  bit   m_on;
  bit   probe;
  logic [7:0] m_sum;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    if (idx == 8'd1) begin
      m_on  = 1'b1;
      m_cnt = 0;
      m_ovf = 1'b0;
      m_sum = 8'd0;
    end
    tick();
  endtask

  task automatic wr_byte(input int a, input logic [7:0] d, input bit fall);
    ioctl_addr = 25'(a);
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    if (fall) ioctl_download = 1'b0;
    if (probe) begin
      #1;
      chk("pass_we", {31'd0, mem_we}, (m_on && a < 8192) ? 32'd1 : 32'd0);
      chk("pass_addr", 32'(mem_addr), 32'(a % 8192));
    end
    if (m_on) begin
      if (a < 8192) begin
        ref_mem[a] = d;
        if (a + 1 > m_cnt) m_cnt = a + 1;
        m_sum = m_sum + d;
      end else begin
        m_ovf = 1'b1;
      end
    end
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    tick();
  endtask

  // Called the cycle after the download fell: run out the mirror and compare everything.
  task automatic settle(input string tag);
    int p;
    int busy;
    int bad;
    if (m_cnt == 0) p = 0;
    else begin
      p = 2048;
      while (p < m_cnt && p < 8192) p = p * 2;
    end
    busy = 0;
    while (mirror_busy === 1'b1 && busy < 20000) begin
      busy++;
      tick();
    end
    chk({tag, "_busy"}, 32'(busy), (p == 0 || p == 8192) ? 32'd0 : 32'(2 * (8192 - p)));
    chk({tag, "_size"}, 32'(cart_size), 32'(p));
    chk({tag, "_present"}, {31'd0, cart_present}, (p != 0) ? 32'd1 : 32'd0);
    chk({tag, "_owns"}, {31'd0, owns_bus}, 32'd0);
    chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, m_ovf});
    if (p != 0 && p < 8192)
      for (int a = p; a < 8192; a++) ref_mem[a] = ref_mem[a % p];
    bad = 0;
    for (int a = 0; a < 8192; a++) if (ram[a] !== ref_mem[a]) bad++;
    chk({tag, "_image"}, 32'(bad), 32'd0);
    m_on = 1'b0;
  endtask

  initial begin
    int bad;
    int base;
    int lim;
    logic [7:0] b0;

    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    probe          = 1'b0;
    m_on           = 1'b0;
    m_cnt          = 0;
    m_ovf          = 1'b0;
    m_sum          = 8'd0;
    repeat (3) tick();
    chk("rst_owns", {31'd0, owns_bus}, 32'd0);
    chk("rst_size", 32'(cart_size), 32'd0);
    chk("rst_present", {31'd0, cart_present}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_busy", {31'd0, mirror_busy}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    reset = 1'b0;
    tick();

    // 2 KB image with data = addr[7:0]
    start_dl(8'd1);
    for (int a = 0; a < 2048; a++) begin
      probe = (a == 0);
      wr_byte(a, 8'(a), 1'b0);
    end
    probe = 1'b0;
    end_dl();
    settle("ld2k");
    chk("ld2k_0800", 32'(ram[13'h0800]), 32'h00);
    chk("ld2k_1000", 32'(ram[13'h1000]), 32'h00);
    chk("ld2k_1800", 32'(ram[13'h1800]), 32'h00);
    chk("ld2k_1fff", 32'(ram[13'h1FFF]), 32'hFF);

    // 3000 bytes rounds to 4 KB, tail of the first copy is old content
    start_dl(8'd1);
    for (int a = 0; a < 3000; a++) wr_byte(a, 8'($urandom), 1'b0);
    end_dl();
    settle("ld3k");
    bad = 0;
    for (int n = 0; n < 4096; n++) if (ram[13'(4096 + n)] !== ram[n]) bad++;
    chk("ld3k_mirror", 32'(bad), 32'd0);

    // Full 8 KB, last byte on the falling edge
    start_dl(8'd1);
    for (int a = 0; a < 8191; a++) wr_byte(a, 8'($urandom), 1'b0);
    wr_byte(8191, 8'($urandom), 1'b1);
    settle("ld8k");

    // 10 KB download overflows the window
    start_dl(8'd1);
    b0 = 8'($urandom);
    wr_byte(0, b0, 1'b0);
    for (int a = 1; a < 10240; a++) begin
      probe = (a == 8192);
      wr_byte(a, 8'($urandom), 1'b0);
    end
    probe = 1'b0;
    end_dl();
    settle("ld10k");
    chk("ld10k_byte0", 32'(ram[0]), 32'(b0));

    // BIOS download must not touch RAM or flags
    base = we_cnt;
    start_dl(8'd0);
    chk("bios_owns", {31'd0, owns_bus}, 32'd0);
    for (int a = 0; a < 16; a++) begin
      probe = (a == 0);
      wr_byte(a, 8'($urandom), 1'b0);
    end
    probe = 1'b0;
    end_dl();
    chk("bios_we", 32'(we_cnt - base), 32'd0);
    chk("bios_size", 32'(cart_size), 32'h2000);
    chk("bios_present", {31'd0, cart_present}, 32'd1);
    chk("bios_ovf", {31'd0, overflow}, 32'd1);

    // Empty cart download
    start_dl(8'd1);
    end_dl();
    settle("ld0");

    // Reset in MWR with dst = 0x0900
    start_dl(8'd1);
    for (int a = 0; a < 2048; a++) wr_byte(a, 8'($urandom), 1'b0);
    end_dl();
    repeat (513) tick();
    chk("rstmw_busy", {31'd0, mirror_busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rstmw_owns", {31'd0, owns_bus}, 32'd0);
    chk("rstmw_present", {31'd0, cart_present}, 32'd0);
    chk("rstmw_size", 32'(cart_size), 32'd0);
    for (int a = 2048; a < 2304; a++) ref_mem[a] = ref_mem[a - 2048];
    m_on = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    bad = 0;
    for (int a = 0; a < 8192; a++) if (ram[a] !== ref_mem[a]) bad++;
    chk("rstmw_image", 32'(bad), 32'd0);

    // New cart download aborts a mirror in progress
    start_dl(8'd1);
    for (int a = 0; a < 2048; a++) wr_byte(a, 8'($urandom), 1'b0);
    wr_byte(9000, 8'h5A, 1'b0);
    end_dl();
    chk("abort_ovf_set", {31'd0, overflow}, 32'd1);
    repeat (100) tick();
    for (int a = 2048; a < 2098; a++) ref_mem[a] = ref_mem[a - 2048];
    start_dl(8'd1);
    chk("abort_owns", {31'd0, owns_bus}, 32'd1);
    chk("abort_busy", {31'd0, mirror_busy}, 32'd0);
    chk("abort_ovf", {31'd0, overflow}, 32'd0);
    chk("abort_present", {31'd0, cart_present}, 32'd0);
    for (int a = 0; a < 5000; a++) wr_byte(a, 8'($urandom), 1'b0);
    end_dl();
    settle("abort_ld");

    // Scattered random writes with idle gaps
    for (int it = 0; it < 2; it++) begin
      lim = (it == 0) ? 2047 : 6000;
      start_dl(8'd1);
      for (int k = 0; k < 200; k++) begin
        wr_byte(int'($urandom_range(0, lim)), 8'($urandom), 1'b0);
        if ($urandom_range(0, 3) == 0) tick();
      end
      if (it == 0) wr_byte(2048, 8'($urandom), 1'b1);
      else end_dl();
      settle((it == 0) ? "rnd0" : "rnd1");
    end

`ifdef ASTRO_CART_CSUM_EN
    start_dl(8'd1);
    for (int a = 0; a < 4; a++) wr_byte(a, 8'hFF, 1'b0);
    end_dl();
    settle("csum_ld");
    chk("csum", 32'(csum), 32'(m_sum));
    chk("csum_fc", 32'(csum), 32'hFC);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
